idli_encode_m: RTL and testbench

IDLI_ENCODE_M -- requirements
Module: idli_encode_m

---
 rtl/idli_pkg.sv | 50 +++++
 rtl/idli_encode_fifo_m.sv | 55 +++++
 rtl/idli_encode_m.sv | 162 ++++++++++++++++
 tb/tb_idli_encode_m.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/idli_pkg.sv
// Shared types for the IDLI instruction encoder: opcode/state enums, field
// widths, and the request record carried through the encoder FIFO.
package idli_pkg;

  typedef logic [1:0]  ctr_t;
  typedef logic [3:0]  slice_t;
  typedef logic [3:0]  reg_t;
  typedef logic [15:0] data_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_ANDN = 4'b0011,
    OP_OR   = 4'b0100,
    OP_XOR  = 4'b0101,
    OP_LD   = 4'b0110,
    OP_ST   = 4'b0111,
    OP_CMP  = 4'b1011
  } enc_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INSN = 2'd1,
    ST_IMM  = 2'd2
  } enc_state_t;

  // Register C naming SP means an immediate word follows the instruction.
  localparam reg_t REG_SP   = 4'b1111;
  localparam ctr_t CTR_LAST = 2'd3;

  typedef struct packed {
    enc_op_t op;
    reg_t    a;
    reg_t    b;
    reg_t    c;
    data_t   imm;
  } enc_req_t;

  function automatic logic op_legal(input enc_op_t op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_ANDN, OP_OR,
      OP_XOR, OP_LD, OP_ST, OP_CMP: legal = 1'b1;
      default:                      legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/idli_encode_fifo_m.sv
// Two-entry request FIFO with a registered ready; a full FIFO refuses a push
// even in a cycle where the head is popped.
module idli_encode_fifo_m #(
  parameter type entry_t = logic [31:0]
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  entry_t     push_data,
  input  logic       pop,
  output entry_t     head,
  output logic       empty,
  output logic       rdy,
  output logic [1:0] level_next
);

  entry_t     mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] level;
  logic       push_ok;
  logic       pop_ok;

  always_comb begin
    push_ok    = push && rdy;
    pop_ok     = pop && (level != 2'd0);
    wr_ptr     = rd_ptr ^ level[0];
    level_next = level + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level  <= 2'd0;
      rd_ptr <= 1'b0;
      rdy    <= 1'b0;
    end else begin
      level <= level_next;
      rdy   <= (level_next != 2'd2);
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by level alone.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (level == 2'd0);

endmodule

// File: rtl/idli_encode_m.sv
// IDLI encoder: queues requests and serialises each instruction word (plus an
// optional immediate word) as nibbles aligned to the shared 4-GCK counter.
module idli_encode_m
  import idli_pkg::*;
(
  input  logic    i_en_gck,
  input  logic    i_en_rst,
  input  ctr_t    i_en_ctr,
  input  logic    i_en_req_vld,
  output logic    o_en_req_rdy,
  input  enc_op_t i_en_req_op,
  input  reg_t    i_en_req_a,
  input  reg_t    i_en_req_b,
  input  reg_t    i_en_req_c,
  input  data_t   i_en_req_imm,
  output slice_t  o_en_slice,
  output logic    o_en_slice_vld,
  output logic    o_en_imm,
  output logic    o_en_err,
  output logic    o_en_busy
);

  enc_state_t state;
  enc_state_t state_next;
  enc_req_t   req_in;
  enc_req_t   head;
  logic       fifo_empty;
  logic [1:0] fifo_level_next;
  logic [15:0] sreg;
  data_t      imm_word;
  logic       need_imm;
  logic       at_last;
  logic       launch_pt;
  logic       to_imm;
  logic       launch;
  logic       drop;
  logic       pop;
  slice_t     slice_d;
  logic       vld_d;
  logic       imm_d;

  assign req_in = {i_en_req_op, i_en_req_a, i_en_req_b, i_en_req_c, i_en_req_imm};

  idli_encode_fifo_m #(
    .entry_t (enc_req_t)
  ) u_fifo (
    .clk        (i_en_gck),
    .rst        (i_en_rst),
    .push       (i_en_req_vld),
    .push_data  (req_in),
    .pop        (pop),
    .head       (head),
    .empty      (fifo_empty),
    .rdy        (o_en_req_rdy),
    .level_next (fifo_level_next)
  );

  // A launch point is a ctr==3 edge where the serialiser is free next period.
  always_comb begin
    at_last   = (i_en_ctr == CTR_LAST);
    launch_pt = 1'b0;
    to_imm    = 1'b0;
    case (state)
      ST_IDLE: launch_pt = at_last;
      ST_INSN: begin
        launch_pt = at_last && !need_imm;
        to_imm    = at_last && need_imm;
      end
      ST_IMM:  launch_pt = at_last;
      default: launch_pt = at_last;
    endcase
    launch = launch_pt && !fifo_empty && op_legal(head.op);
    drop   = launch_pt && !fifo_empty && !op_legal(head.op);
    pop    = launch || drop;
  end

  always_ff @(posedge i_en_gck) begin
    if (i_en_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (launch) state_next = ST_INSN;
        else        state_next = ST_IDLE;
      end
      ST_INSN: begin
        if (to_imm)       state_next = ST_IMM;
        else if (launch)  state_next = ST_INSN;
        else if (at_last) state_next = ST_IDLE;
        else              state_next = ST_INSN;
      end
      ST_IMM: begin
        if (launch)       state_next = ST_INSN;
        else if (at_last) state_next = ST_IDLE;
        else              state_next = ST_IMM;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    slice_d = 4'h0;
    vld_d   = 1'b0;
    imm_d   = 1'b0;
    if (launch) begin
      slice_d = head.op;
      vld_d   = 1'b1;
    end else if (to_imm) begin
      slice_d = imm_word[15:12];
      vld_d   = 1'b1;
      imm_d   = 1'b1;
    end else if ((state == ST_INSN || state == ST_IMM) && !at_last) begin
      slice_d = sreg[15:12];
      vld_d   = 1'b1;
      imm_d   = (state == ST_IMM);
    end else begin
      slice_d = 4'h0;
      vld_d   = 1'b0;
      imm_d   = 1'b0;
    end
  end

  always_ff @(posedge i_en_gck) begin
    if (i_en_rst) begin
      o_en_slice     <= 4'h0;
      o_en_slice_vld <= 1'b0;
      o_en_imm       <= 1'b0;
      o_en_err       <= 1'b0;
      o_en_busy      <= 1'b0;
    end else begin
      o_en_slice     <= slice_d;
      o_en_slice_vld <= vld_d;
      o_en_imm       <= imm_d;
      o_en_err       <= drop;
      o_en_busy      <= (state_next != ST_IDLE) || (fifo_level_next != 2'd0);
    end
  end

  // Slice 0 leaves directly from the FIFO head; the rest shift out of sreg.
  always_ff @(posedge i_en_gck) begin
    if (i_en_rst) begin
      sreg     <= 16'h0000;
      imm_word <= 16'h0000;
      need_imm <= 1'b0;
    end else if (launch) begin
      sreg     <= {head.a, head.b, head.c, 4'h0};
      imm_word <= head.imm;
      need_imm <= (head.c == REG_SP);
    end else if (to_imm) begin
      sreg <= {imm_word[11:0], 4'h0};
    end else begin
      sreg <= {sreg[11:0], 4'h0};
    end
  end

endmodule

// File: tb/tb_idli_encode_m.sv
// Bench for idli_encode_m: directed vector table, hand-written corner sequences,
// and random traffic, all cross-checked every cycle against a queue model.
module tb_idli_encode_m;
  import idli_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic    rst;
  ctr_t    ctr;
  logic    req_vld;
  enc_op_t req_op;
  reg_t    req_a, req_b, req_c;
  data_t   req_imm;
  logic    req_rdy;
  slice_t  slice;
  logic    slice_vld, imm_flag, err, busy;

  idli_encode_m dut (
    .i_en_gck       (clk),
    .i_en_rst       (rst),
    .i_en_ctr       (ctr),
    .i_en_req_vld   (req_vld),
    .o_en_req_rdy   (req_rdy),
    .i_en_req_op    (req_op),
    .i_en_req_a     (req_a),
    .i_en_req_b     (req_b),
    .i_en_req_c     (req_c),
    .i_en_req_imm   (req_imm),
    .o_en_slice     (slice),
    .o_en_slice_vld (slice_vld),
    .o_en_imm       (imm_flag),
    .o_en_err       (err),
    .o_en_busy      (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request queue plus a queue of the nibbles still to be
  // emitted. A new word starts at a ctr==3 edge only once the emit queue is dry.
  typedef struct {logic [3:0] op, a, b, c; logic [15:0] imm;} req_s;
  typedef struct {logic [3:0] nib; logic imm;} out_s;
  req_s mq[$];
  out_s oq[$];
  logic m_rdy = 1'b0, m_vld = 1'b0, m_imm = 1'b0, m_err = 1'b0, m_busy = 1'b0;
  logic [3:0] m_slice = 4'h0;

  function automatic bit legal(input logic [3:0] op);
    return (op <= 4'd7) || (op == 4'd11);
  endfunction

  function automatic out_s mk(input logic [3:0] nib, input logic im);
    out_s o;
    o.nib = nib;
    o.imm = im;
    return o;
  endfunction

  task automatic model_edge(input logic s_rst, input logic [1:0] s_ctr, input logic s_vld, input req_s r);
    req_s h;
    out_s o;
    if (s_rst) begin
      mq.delete();
      oq.delete();
      m_rdy = 1'b0; m_vld = 1'b0; m_imm = 1'b0; m_err = 1'b0; m_busy = 1'b0; m_slice = 4'h0;
      return;
    end
    m_err = 1'b0;
    if (s_ctr == 2'd3 && oq.size() == 0 && mq.size() > 0) begin
      h = mq.pop_front();
      if (!legal(h.op)) begin
        m_err = 1'b1;
      end else begin
        oq.push_back(mk(h.op, 1'b0));
        oq.push_back(mk(h.a, 1'b0));
        oq.push_back(mk(h.b, 1'b0));
        oq.push_back(mk(h.c, 1'b0));
        if (h.c == 4'hF)
          for (int k = 0; k < 4; k++) oq.push_back(mk(h.imm[15-4*k -: 4], 1'b1));
      end
    end
    if (s_vld && m_rdy) mq.push_back(r);
    if (oq.size() > 0) begin
      o = oq.pop_front();
      m_vld = 1'b1; m_slice = o.nib; m_imm = o.imm;
    end else begin
      m_vld = 1'b0; m_slice = 4'h0; m_imm = 1'b0;
    end
    m_rdy  = (mq.size() < 2);
    m_busy = (mq.size() > 0) || m_vld;
  endtask

  // One clock: sample the inputs the DUT sees, advance, check against the model.
  task automatic step();
    logic s_rst, s_vld;
    logic [1:0] s_ctr;
    req_s r;
    s_rst = rst; s_ctr = ctr; s_vld = req_vld;
    r.op = req_op; r.a = req_a; r.b = req_b; r.c = req_c; r.imm = req_imm;
    @(posedge clk);
    #1;
    model_edge(s_rst, s_ctr, s_vld, r);
    check("m_slice", {12'h0, slice}, {12'h0, m_slice});
    check("m_vld", {15'h0, slice_vld}, {15'h0, m_vld});
    check("m_imm", {15'h0, imm_flag}, {15'h0, m_imm});
    check("m_err", {15'h0, err}, {15'h0, m_err});
    check("m_busy", {15'h0, busy}, {15'h0, m_busy});
    check("m_rdy", {15'h0, req_rdy}, {15'h0, m_rdy});
    ctr = ctr + 2'd1;
  endtask

  task automatic set_req(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [15:0] imm);
    req_vld = 1'b1;
    req_op  = enc_op_t'(op);
    req_a = a; req_b = b; req_c = c; req_imm = imm;
  endtask

  task automatic wait_ctr(input logic [1:0] v);
    int n = 0;
    while (ctr != v && n < 8) begin step(); n++; end
  endtask

  task automatic drain();
    int n = 0;
    req_vld = 1'b0;
    while ((oq.size() != 0 || mq.size() != 0 || busy) && n < 64) begin step(); n++; end
    check("drain_busy", {15'h0, busy}, 16'h0);
  endtask

  typedef struct {
    logic [3:0] op, a, b, c;
    logic [15:0] imm;
    logic [31:0] nibs;
    logic [7:0]  immf;
    int          n;
  } vec_s;
  vec_s vt[5];
  logic [47:0] seq;
  logic [3:0]  lops[9];

  initial begin
    vt[0] = '{4'h0, 4'h1, 4'h2, 4'h3, 16'h0000, 32'h0123_0000, 8'h00, 4};
    vt[1] = '{4'h1, 4'h4, 4'h5, 4'hF, 16'hBEEF, 32'h145F_BEEF, 8'h0F, 8};
    vt[2] = '{4'h6, 4'hA, 4'hB, 4'h7, 16'h1234, 32'h6AB7_0000, 8'h00, 4};
    vt[3] = '{4'hB, 4'h2, 4'h3, 4'hF, 16'h0A5C, 32'hB23F_0A5C, 8'h0F, 8};
    vt[4] = '{4'h7, 4'h0, 4'hE, 4'hF, 16'h9001, 32'h70EF_9001, 8'h0F, 8};
    lops  = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hB};

    rst = 1'b1; ctr = 2'd0; req_vld = 1'b0;
    req_op = OP_ADD; req_a = 4'h0; req_b = 4'h0; req_c = 4'h0; req_imm = 16'h0;
    repeat (3) step();
    check("reset_vld", {15'h0, slice_vld}, 16'h0);
    check("reset_slice", {12'h0, slice}, 16'h0);
    check("reset_rdy", {15'h0, req_rdy}, 16'h0);
    check("reset_busy", {15'h0, busy}, 16'h0);
    rst = 1'b0;
    step();
    check("rdy_after_reset", {15'h0, req_rdy}, 16'h1);

    // Single requests accepted at ctr==2 appear from ctr==0 of the next period.
    for (int i = 0; i < 5; i++) begin
      drain();
      wait_ctr(2'd2);
      check($sformatf("vec%0d_rdy", i), {15'h0, req_rdy}, 16'h1);
      set_req(vt[i].op, vt[i].a, vt[i].b, vt[i].c, vt[i].imm);
      step();
      req_vld = 1'b0;
      step();
      for (int k = 0; k < 8; k++) begin
        check($sformatf("vec%0d_slice%0d", i, k), {12'h0, slice}, {12'h0, vt[i].nibs[31-4*k -: 4]});
        check($sformatf("vec%0d_vld%0d", i, k), {15'h0, slice_vld}, {15'h0, (k < vt[i].n)});
        check($sformatf("vec%0d_imm%0d", i, k), {15'h0, imm_flag}, {15'h0, vt[i].immf[7-k]});
        step();
      end
    end

    // Three back-to-back requests: third held off while full, no gap between words.
    drain();
    wait_ctr(2'd0);
    set_req(4'h4, 4'h1, 4'h2, 4'h3, 16'h0);
    step();
    check("b2b_rdy_one", {15'h0, req_rdy}, 16'h1);
    set_req(4'h5, 4'h6, 4'h7, 4'h8, 16'h0);
    step();
    check("b2b_rdy_full", {15'h0, req_rdy}, 16'h0);
    set_req(4'h2, 4'h9, 4'hA, 4'hB, 16'h0);
    step();
    check("b2b_rdy_hold", {15'h0, req_rdy}, 16'h0);
    step();
    check("b2b_rdy_pop", {15'h0, req_rdy}, 16'h1);
    seq = 48'h4123_5678_29AB;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("b2b_slice%0d", k), {12'h0, slice}, {12'h0, seq[47-4*k -: 4]});
      check($sformatf("b2b_vld%0d", k), {15'h0, slice_vld}, 16'h1);
      step();
      if (k == 0) req_vld = 1'b0;
    end
    check("b2b_end_vld", {15'h0, slice_vld}, 16'h0);

    // Illegal opcode ahead of a legal XOR.
    drain();
    wait_ctr(2'd1);
    set_req(4'hF, 4'h1, 4'h2, 4'h3, 16'h0);
    step();
    set_req(4'h5, 4'h1, 4'h2, 4'h3, 16'h0);
    step();
    req_vld = 1'b0;
    check("ill_err_pre", {15'h0, err}, 16'h0);
    step();
    check("ill_err_pulse", {15'h0, err}, 16'h1);
    check("ill_no_vld", {15'h0, slice_vld}, 16'h0);
    step();
    check("ill_err_single", {15'h0, err}, 16'h0);
    repeat (3) step();
    seq = 48'h5123_0000_0000;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ill_xor_slice%0d", k), {12'h0, slice}, {12'h0, seq[47-4*k -: 4]});
      check($sformatf("ill_xor_vld%0d", k), {15'h0, slice_vld}, 16'h1);
      step();
    end

    // Reset at ctr==1 of an immediate period.
    drain();
    wait_ctr(2'd2);
    set_req(4'h1, 4'h4, 4'h5, 4'hF, 16'hBEEF);
    step();
    req_vld = 1'b0;
    step();
    repeat (5) step();
    check("rst_pre_imm", {15'h0, imm_flag}, 16'h1);
    check("rst_pre_slice", {12'h0, slice}, 16'h000E);
    rst = 1'b1;
    step();
    check("rst_vld", {15'h0, slice_vld}, 16'h0);
    check("rst_busy", {15'h0, busy}, 16'h0);
    check("rst_rdy", {15'h0, req_rdy}, 16'h0);
    step();
    rst = 1'b0;
    step();
    check("rst_rdy_after", {15'h0, req_rdy}, 16'h1);
    check("rst_busy_after", {15'h0, busy}, 16'h0);
    repeat (8) begin
      step();
      check("rst_no_resume", {15'h0, slice_vld}, 16'h0);
    end

    // Random traffic checked by the model alone.
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      req_vld = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) req_op = enc_op_t'($urandom_range(0, 15));
      else req_op = enc_op_t'(lops[$urandom_range(0, 8)]);
      req_a = 4'($urandom_range(0, 15));
      req_b = 4'($urandom_range(0, 15));
      req_c = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      req_imm = 16'($urandom_range(0, 65535));
      step();
    end
    rst = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
